// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared constants and FSM encoding for the instruction-fetch stage
package if_fetch_unit_pkg;
  localparam int INTERNAL_BITS = 32;
  localparam int ENTRY_BITS = 2 * INTERNAL_BITS;
  localparam logic [INTERNAL_BITS-1:0] NOP = 32'h00000013;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} fetch_state_t;
endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: small circular buffer of {pc, inst} fetch entries
//   push/pop/flush controls; count, empty and head (oldest entry) outputs.
//   flush empties the buffer and wins over a same-cycle push or pop.
module if_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic [W-1:0]  head
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= pop ? rd + 1'b1 : rd;
      wr <= push ? wr + 1'b1 : wr;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
  assign empty = count == '0;
  assign head = mem[rd];
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage owning the PC, fetching over req/ack into a buffer feeding IF/ID
//   in : clk, rst (async, active-high), stall, redirect_valid/redirect_pc, imem_ack/imem_rdata
//   out: imem_req/imem_addr, Instruction_out/PC_out/inst_valid (NOP / 0 when nothing buffered)
module if_fetch_unit import if_fetch_unit_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_out,
  output logic [31:0] PC_out,
  output logic        inst_valid
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  fetch_state_t state, state_n;
  logic [31:0] fetch_pc, addr_q;
  logic kill, ack, push, pop, issue;
  logic [CW-1:0] count, count_nx;
  logic empty;
  logic [ENTRY_BITS-1:0] head;
  assign ack = state == BUSY && imem_ack;
  // A word acked under a pending or same-cycle redirect belongs to the abandoned path.
  assign push = ack && !kill && !redirect_valid;
  assign pop = !empty && !stall && !redirect_valid;
  assign count_nx = count + CW'(push) - CW'(pop);
  // Credit includes the outstanding request, so a completing push can never overflow.
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = count < DEPTH_C && !redirect_valid ? BUSY : IDLE;
    else if (imem_ack)
      state_n = count_nx < DEPTH_C && !redirect_valid ? BUSY : IDLE;
  end
  assign issue = state_n == BUSY && (state == IDLE || ack);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q <= '0;
      kill <= 1'b0;
    end else begin
      state <= state_n;
      fetch_pc <= redirect_valid ? redirect_pc : issue ? fetch_pc + 32'd4 : fetch_pc;
      kill <= redirect_valid && state == BUSY && !imem_ack ? 1'b1 : ack ? 1'b0 : kill;
      addr_q <= issue ? fetch_pc : addr_q;
    end
  if_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_BITS)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din({addr_q, imem_rdata}),
    .count(count),
    .empty(empty),
    .head(head)
  );
  assign imem_req = state == BUSY;
  assign imem_addr = imem_req ? addr_q : 32'h0;
  assign inst_valid = !empty;
  assign Instruction_out = inst_valid ? head[31:0] : NOP;
  assign PC_out = inst_valid ? head[63:32] : 32'h0;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed per-cycle vectors plus a reset-mid-transfer sequence
module tb_if_fetch_unit;
  localparam logic [31:0] NOP_W = 32'h00000013;
  localparam logic [31:0] SALT = 32'h5A5A0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata, Instruction_out, PC_out;
  logic inst_valid;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ SALT;
  if_fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .Instruction_out(Instruction_out),
    .PC_out(PC_out),
    .inst_valid(inst_valid)
  );
  typedef struct {
    logic rst, stall, rv;
    logic [31:0] rpc;
    logic ack, req;
    logic [31:0] addr;
    logic valid;
    logic [31:0] pc;
  } vec_t;
  vec_t tv[$];
  function automatic void add(input logic r, s, rv, input logic [31:0] rpc, input logic a, rq,
                              input logic [31:0] ad, input logic v, input logic [31:0] pc);
    tv.push_back('{r, s, rv, rpc, a, rq, ad, v, pc});
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic rq, input logic [31:0] ad,
                         input logic v, input logic [31:0] pc);
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, rq});
    chk({tag, ".addr"}, imem_addr, ad);
    chk({tag, ".valid"}, {31'b0, inst_valid}, {31'b0, v});
    chk({tag, ".pc"}, PC_out, pc);
    chk({tag, ".inst"}, Instruction_out, v ? pc ^ SALT : NOP_W);
  endtask
  initial begin
    add(1,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,1, 0,0,0,0);
    add(0,0,0,0,1, 1,0,0,0);
    add(0,0,0,0,1, 1,4,1,0);
    add(0,0,0,0,1, 1,8,1,4);
    add(0,1,0,0,1, 1,12,1,8);
    for (int k = 0; k < 4; k++) add(0,1,0,0,1, 0,0,1,8);
    add(0,0,0,0,1, 0,0,1,8);
    add(0,0,0,0,1, 0,0,1,12);
    add(0,0,0,0,1, 1,16,0,0);
    add(0,0,0,0,0, 1,20,1,16);
    add(0,0,1,32'h100,0, 1,20,0,0);
    add(0,0,0,0,0, 1,20,0,0);
    add(0,0,0,0,0, 1,20,0,0);
    add(0,0,0,0,1, 1,20,0,0);
    add(0,0,0,0,1, 1,32'h100,0,0);
    add(0,0,1,32'h200,1, 1,32'h104,1,32'h100);
    add(0,0,0,0,1, 0,0,0,0);
    add(0,0,0,0,0, 1,32'h200,0,0);
    add(0,0,0,0,1, 1,32'h200,0,0);
    add(0,0,0,0,0, 1,32'h204,1,32'h200);
    add(0,0,1,32'hFFFFFFFC,1, 1,32'h204,0,0);
    add(0,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,1, 1,32'hFFFFFFFC,0,0);
    add(0,0,0,0,0, 1,0,1,32'hFFFFFFFC);
    add(0,0,0,0,0, 1,0,0,0);
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].rst;
      stall = tv[i].stall;
      redirect_valid = tv[i].rv;
      redirect_pc = tv[i].rpc;
      imem_ack = tv[i].ack;
      #1;
      chk_all($sformatf("v%0d", i), tv[i].req, tv[i].addr, tv[i].valid, tv[i].pc);
    end
    @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    chk_all("pre_rst", 1'b1, 32'h4, 1'b1, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1;
    #1;
    chk_all("late_ack", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    chk_all("restart", 1'b1, 32'h0, 1'b0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
